// File: rtl/node_input_arbiter_pkg.sv
// Shared definitions for the node ingress arbiter: source codes, FSM states,
// header field layout and the round-robin channel picker.
package node_input_arbiter_pkg;

  localparam logic [1:0] SRC_SELF  = 2'b00;
  localparam logic [1:0] SRC_LEFT  = 2'b01;
  localparam logic [1:0] SRC_RIGHT = 2'b10;

  // Routing header occupies the top HDR_BITS of each word and is never altered here.
  localparam int unsigned HDR_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } arb_state_t;

  // Pick the first non-empty channel after 'last' in self->left->right order.
  // ne is {right,left,self}; caller guarantees at least one bit is set.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] ne);
    logic [1:0]  pick;
    int unsigned cand;
    pick = last;
    // Descending scan so the nearest candidate after 'last' is written last and wins.
    for (int unsigned k = 3; k >= 1; k--) begin
      cand = (int'(last) + k) % 3;
      if (ne[cand]) pick = 2'(cand);
    end
    return pick;
  endfunction

endpackage

// File: rtl/node_input_arbiter_fifo.sv
// Per-channel first-word-fall-through FIFO. A push into a full FIFO is accepted
// when a pop happens at the same edge; otherwise it is dropped and flagged.
module node_input_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care after reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/node_input_arbiter.sv
// Ingress arbiter for oneDimensionalNode: buffers self/left/right words and issues
// them one at a time as a single-cycle CS strobe followed by a fixed idle gap.
module node_input_arbiter
  import node_input_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inSelfData,
  input  logic             inSelfCS,
  input  logic [WIDTH-1:0] inLeftData,
  input  logic             inLeftCS,
  input  logic [WIDTH-1:0] inRightData,
  input  logic             inRightCS,
  input  logic             nodeBusy,
  output logic [WIDTH-1:0] shiftInData,
  output logic             shiftInCS,
  output logic [1:0]       shiftInSource,
  output logic             pending,
  output logic [2:0]       overflow
);

  localparam logic [3:0] GAP_INIT = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  arb_state_t       state;
  logic [3:0]       gap_cnt;
  logic [1:0]       last_src;
  logic [WIDTH-1:0] dout_s, dout_l, dout_r;
  logic             empty_s, empty_l, empty_r;
  logic             full_s, full_l, full_r;
  logic             drop_s, drop_l, drop_r;
  logic             pop_s, pop_l, pop_r;
  logic [2:0]       ne;
  logic             can_grant;
  logic [1:0]       grant_src;
  logic [WIDTH-1:0] grant_data;

  node_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_self (
    .clk(clk), .reset(reset), .push(inSelfCS), .pop(pop_s), .din(inSelfData),
    .dout(dout_s), .full(full_s), .empty(empty_s), .drop(drop_s)
  );

  node_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_left (
    .clk(clk), .reset(reset), .push(inLeftCS), .pop(pop_l), .din(inLeftData),
    .dout(dout_l), .full(full_l), .empty(empty_l), .drop(drop_l)
  );

  node_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_right (
    .clk(clk), .reset(reset), .push(inRightCS), .pop(pop_r), .din(inRightData),
    .dout(dout_r), .full(full_r), .empty(empty_r), .drop(drop_r)
  );

  assign ne      = {!empty_r, !empty_l, !empty_s};
  assign pending = |ne;

  // Grant decision: IDLE, back-to-back ISSUE when GAP==0, or the last GAP cycle
  // (which folds the IDLE evaluation into the gap's final edge).
  always_comb begin
    can_grant  = 1'b0;
    grant_src  = rr_pick(last_src, ne);
    grant_data = dout_s;
    pop_s      = 1'b0;
    pop_l      = 1'b0;
    pop_r      = 1'b0;
    if (!nodeBusy && pending) begin
      case (state)
        ST_IDLE:  can_grant = 1'b1;
        ST_ISSUE: can_grant = (GAP == 0);
        ST_GAP:   can_grant = (gap_cnt == '0);
        default:  can_grant = 1'b0;
      endcase
    end
    case (grant_src)
      SRC_LEFT:  grant_data = dout_l;
      SRC_RIGHT: grant_data = dout_r;
      default:   grant_data = dout_s;
    endcase
    pop_s = can_grant && (grant_src == SRC_SELF);
    pop_l = can_grant && (grant_src == SRC_LEFT);
    pop_r = can_grant && (grant_src == SRC_RIGHT);
  end

  // Issue FSM with registered outputs, round-robin pointer and sticky drop flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      last_src      <= SRC_RIGHT;
      shiftInData   <= '0;
      shiftInCS     <= 1'b0;
      shiftInSource <= SRC_SELF;
      overflow      <= '0;
    end else begin
      overflow  <= overflow | {drop_r, drop_l, drop_s};
      shiftInCS <= can_grant;
      if (can_grant) begin
        shiftInData   <= grant_data;
        shiftInSource <= grant_src;
        last_src      <= grant_src;
        state         <= ST_ISSUE;
      end else begin
        case (state)
          ST_ISSUE: begin
            if (GAP == 0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= GAP_INIT;
              state   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (gap_cnt == '0) state <= ST_IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_node_input_arbiter.sv
// Directed bench for node_input_arbiter: table-driven issue/latency vectors plus
// sequences for overflow, busy-during-gap, mid-issue reset and a GAP=0 build.
module tb_node_input_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_d, l_d, r_d;
  logic        s_cs, l_cs, r_cs, busy;
  logic [31:0] o_data;
  logic        o_cs;
  logic [1:0]  o_src;
  logic        o_pend;
  logic [2:0]  o_ovf;

  logic [31:0] g_s_d, g_l_d, g_r_d;
  logic        g_s_cs, g_l_cs, g_r_cs, g_busy;
  logic [31:0] g_data;
  logic        g_cs;
  logic [1:0]  g_src;
  logic        g_pend;
  logic [2:0]  g_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  node_input_arbiter #(.WIDTH(32), .DEPTH(4), .GAP(2)) dut (
    .clk(clk), .reset(reset),
    .inSelfData(s_d), .inSelfCS(s_cs),
    .inLeftData(l_d), .inLeftCS(l_cs),
    .inRightData(r_d), .inRightCS(r_cs),
    .nodeBusy(busy),
    .shiftInData(o_data), .shiftInCS(o_cs), .shiftInSource(o_src),
    .pending(o_pend), .overflow(o_ovf)
  );

  node_input_arbiter #(.WIDTH(32), .DEPTH(4), .GAP(0)) dut_g0 (
    .clk(clk), .reset(reset),
    .inSelfData(g_s_d), .inSelfCS(g_s_cs),
    .inLeftData(g_l_d), .inLeftCS(g_l_cs),
    .inRightData(g_r_d), .inRightCS(g_r_cs),
    .nodeBusy(g_busy),
    .shiftInData(g_data), .shiftInCS(g_cs), .shiftInSource(g_src),
    .pending(g_pend), .overflow(g_ovf)
  );

  typedef struct {
    logic        s_cs, l_cs, r_cs;
    logic [31:0] s_d, l_d, r_d;
    logic        e_cs;
    logic [1:0]  e_src;
    logic [31:0] e_data;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic sc, input logic [31:0] sd,
                               input logic lc, input logic [31:0] ld,
                               input logic rc, input logic [31:0] rd,
                               input logic ecs, input logic [1:0] esrc,
                               input logic [31:0] edata, input logic epend);
    vec_t v;
    v.s_cs = sc; v.s_d = sd; v.l_cs = lc; v.l_d = ld; v.r_cs = rc; v.r_d = rd;
    v.e_cs = ecs; v.e_src = esrc; v.e_data = edata; v.e_pend = epend;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] got_data [$];
    int          got_cyc  [$];
    logic [1:0]  got_src  [$];

    reset = 1'b1;
    s_d = '0; l_d = '0; r_d = '0; s_cs = 1'b0; l_cs = 1'b0; r_cs = 1'b0; busy = 1'b0;
    g_s_d = '0; g_l_d = '0; g_r_d = '0; g_s_cs = 1'b0; g_l_cs = 1'b0; g_r_cs = 1'b0; g_busy = 1'b0;
    tick();
    tick();
    chk("rst_cs",   32'(o_cs),   32'd0);
    chk("rst_data", o_data,      32'd0);
    chk("rst_src",  32'(o_src),  32'd0);
    chk("rst_pend", 32'(o_pend), 32'd0);
    chk("rst_ovf",  32'(o_ovf),  32'd0);
    reset = 1'b0;

    // Case 1: single right word; case 2: simultaneous left+self, self wins.
    vecs.push_back(mkv(0, 0, 0, 0, 1, 32'hC4000000, 0, 2'b00, 32'h0,        1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            1, 2'b10, 32'hC4000000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b10, 32'hC4000000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b10, 32'hC4000000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b10, 32'hC4000000, 0));
    vecs.push_back(mkv(1, 32'hC4000000, 1, 32'd73, 0, 0, 0, 2'b10, 32'hC4000000, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            1, 2'b00, 32'hC4000000, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b00, 32'hC4000000, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b00, 32'hC4000000, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            1, 2'b01, 32'd73,       0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b01, 32'd73,       0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b01, 32'd73,       0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,            0, 2'b01, 32'd73,       0));

    for (int i = 0; i < vecs.size(); i++) begin
      s_cs = vecs[i].s_cs; s_d = vecs[i].s_d;
      l_cs = vecs[i].l_cs; l_d = vecs[i].l_d;
      r_cs = vecs[i].r_cs; r_d = vecs[i].r_d;
      tick();
      chk($sformatf("v%0d_cs", i),   32'(o_cs),   32'(vecs[i].e_cs));
      chk($sformatf("v%0d_src", i),  32'(o_src),  32'(vecs[i].e_src));
      chk($sformatf("v%0d_data", i), o_data,      vecs[i].e_data);
      chk($sformatf("v%0d_pend", i), 32'(o_pend), 32'(vecs[i].e_pend));
    end
    s_cs = 1'b0; l_cs = 1'b0; r_cs = 1'b0;

    // Case 3: five left pushes while busy; fifth is dropped.
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      l_cs = 1'b1; l_d = 32'd100 + 32'(k);
      tick();
      chk($sformatf("ovf_push%0d", k), 32'(o_ovf), (k == 4) ? 32'h2 : 32'h0);
      chk($sformatf("busy_cs%0d", k),  32'(o_cs),  32'd0);
    end
    l_cs = 1'b0;
    busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_cs) begin
        got_data.push_back(o_data);
        got_cyc.push_back(c);
        got_src.push_back(o_src);
      end
    end
    chk("drain_count", 32'(got_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      chk($sformatf("drain_data%0d", k), got_data[k], 32'd100 + 32'(k));
      chk($sformatf("drain_src%0d", k),  32'(got_src[k]), 32'd1);
      if (k > 0) chk($sformatf("drain_gap%0d", k), 32'(got_cyc[k] - got_cyc[k-1]), 32'd3);
    end
    chk("drain_ovf_sticky", 32'(o_ovf), 32'h2);

    // Case 4: nodeBusy raised during GAP holds off the next grant.
    s_cs = 1'b1; s_d = 32'h11;
    tick();
    chk("b4_pend", 32'(o_pend), 32'd1);
    s_d = 32'h22;
    tick();
    chk("b4_cs1",   32'(o_cs), 32'd1);
    chk("b4_data1", o_data,    32'h11);
    s_cs = 1'b0;
    tick();
    chk("b4_gap_cs", 32'(o_cs), 32'd0);
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("b4_hold_cs%0d", k),   32'(o_cs), 32'd0);
      chk($sformatf("b4_hold_data%0d", k), o_data,    32'h11);
    end
    busy = 1'b0;
    tick();
    chk("b4_cs2",   32'(o_cs),  32'd1);
    chk("b4_data2", o_data,     32'h22);
    chk("b4_src2",  32'(o_src), 32'd0);
    tick(); tick(); tick();

    // Case 5: reset while a word is in ISSUE with all channels backlogged.
    busy = 1'b1;
    s_cs = 1'b1; l_cs = 1'b1; r_cs = 1'b1;
    s_d = 32'hA0; l_d = 32'hB0; r_d = 32'hC0;
    tick();
    tick();
    s_cs = 1'b0; l_cs = 1'b0; r_cs = 1'b0;
    busy = 1'b0;
    tick();
    chk("r5_issue_cs", 32'(o_cs), 32'd1);
    reset = 1'b1;
    tick();
    chk("r5_cs",   32'(o_cs),   32'd0);
    chk("r5_pend", 32'(o_pend), 32'd0);
    chk("r5_ovf",  32'(o_ovf),  32'd0);
    chk("r5_data", o_data,      32'd0);
    reset = 1'b0;
    r_cs = 1'b1; r_d = 32'hC4000000;
    tick();
    r_cs = 1'b0;
    chk("r5_p1_cs", 32'(o_cs), 32'd0);
    tick();
    chk("r5_p1_cs2",  32'(o_cs),  32'd1);
    chk("r5_p1_data", o_data,     32'hC4000000);
    chk("r5_p1_src",  32'(o_src), 32'd2);
    tick();
    chk("r5_p1_cs3", 32'(o_cs), 32'd0);

    // Case 6: GAP=0 instance, all channels backlogged -> back-to-back rotation.
    g_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      g_s_cs = 1'b1; g_l_cs = 1'b1; g_r_cs = 1'b1;
      g_s_d = 32'h100 + 32'(k); g_l_d = 32'h200 + 32'(k); g_r_d = 32'h300 + 32'(k);
      tick();
    end
    g_s_cs = 1'b0; g_l_cs = 1'b0; g_r_cs = 1'b0;
    g_busy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("g0_cs%0d", k),   32'(g_cs),  32'd1);
      chk($sformatf("g0_src%0d", k),  32'(g_src), 32'(k % 3));
      chk($sformatf("g0_data%0d", k), g_data,     32'h100 * 32'((k % 3) + 1) + 32'(k / 3));
    end
    tick();
    chk("g0_end_cs",   32'(g_cs),   32'd0);
    chk("g0_end_pend", 32'(g_pend), 32'd0);
    chk("g0_ovf",      32'(g_ovf),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
